// File: rtl/airi5c_uart_rx.sv
// airi5c_uart_rx: UART frame receiver with runtime bit period, parity and frame checking.
// Optional build macro UART_RX_NOISE_FILTER_EN enables the three-sample majority filter and noise_error.
module airi5c_uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        rx,
  input  logic [2:0]  data_bits,
  input  logic [1:0]  parity,
  input  logic [1:0]  stop_bits,
  input  logic [23:0] c_bits,
  output logic [8:0]  data,
  output logic        valid,
  output logic        noise_error,
  output logic        parity_error,
  output logic        frame_error,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic parity9(input logic [8:0] v);
    return ^v;
  endfunction

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rx_prev_q, rx_prev_d;
  state_t                 state_q, state_d;
  logic [23:0]            timer_q, timer_d;
  logic [23:0]            c_q, c_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [3:0]             nbits_q, nbits_d;
  logic                   par_en_q, par_en_d;
  logic                   par_odd_q, par_odd_d;
  logic [8:0]             shreg_q, shreg_d;
  logic [1:0]             samp_q, samp_d;
  logic                   noise_acc_q, noise_acc_d;
  logic                   perr_acc_q, perr_acc_d;
  logic [8:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   noise_q, noise_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   busy_q, busy_d;

  logic        rx_s;
  logic        fall_s;
  logic [23:0] sp0_s, sp1_s, sp2_s;
  logic        at_sp0_s, at_sp1_s, at_sp2_s;
  logic        end_of_bit_s;
  logic [23:0] timer_next_s;
  logic        par_en_in_s;
  logic        bit_val_s, bit_noisy_s, stop_noisy_s;
  logic        unused_s;

  assign rx_s         = sync_q[SYNC_STAGES-1];
  assign fall_s       = rx_prev_q & ~rx_s;
  assign sp1_s        = c_q >> 1;
  assign sp0_s        = sp1_s - (c_q >> 4);
  assign sp2_s        = sp1_s + (c_q >> 4);
  assign at_sp0_s     = (timer_q == sp0_s);
  assign at_sp1_s     = (timer_q == sp1_s);
  assign at_sp2_s     = (timer_q == sp2_s);
  assign end_of_bit_s = (timer_q == (c_q - 24'd1));
  assign timer_next_s = end_of_bit_s ? 24'd0 : (timer_q + 24'd1);
  assign par_en_in_s  = (parity == 2'd1) || (parity == 2'd2);

  // Bit decision: majority of early/centre/late samples, the late one being the live line at sp2.
  // The stop bit is decided at its centre, so only early vs centre can disagree there.
`ifdef UART_RX_NOISE_FILTER_EN
  always_comb begin
    bit_val_s    = maj3(samp_q[0], samp_q[1], rx_s);
    bit_noisy_s  = (samp_q[0] != samp_q[1]) || (samp_q[1] != rx_s);
    stop_noisy_s = (samp_q[0] != rx_s);
    unused_s     = ^stop_bits;
  end
`else
  always_comb begin
    bit_val_s    = samp_q[1];
    bit_noisy_s  = 1'b0;
    stop_noisy_s = 1'b0;
    unused_s     = ^{stop_bits, samp_q[0]};
  end
`endif

  // Next-state logic: synchroniser, bit timer, frame FSM and output staging.
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], rx};
    rx_prev_d   = rx_s;
    state_d     = state_q;
    timer_d     = timer_q;
    c_d         = c_q;
    nbits_d     = nbits_q;
    par_en_d    = par_en_q;
    par_odd_d   = par_odd_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    samp_d      = samp_q;
    noise_acc_d = noise_acc_q;
    perr_acc_d  = perr_acc_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    noise_d     = noise_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;

    if (at_sp0_s) begin
      samp_d[0] = rx_s;
    end else begin
      samp_d[0] = samp_q[0];
    end
    if (at_sp1_s) begin
      samp_d[1] = rx_s;
    end else begin
      samp_d[1] = samp_q[1];
    end

    case (state_q)
      S_IDLE: begin
        if (fall_s && (c_bits >= 24'd16)) begin
          state_d     = S_START;
          timer_d     = 24'd0;
          c_d         = c_bits;
          par_en_d    = par_en_in_s;
          par_odd_d   = (parity == 2'd1);
          bit_cnt_d   = 4'd0;
          shreg_d     = 9'd0;
          noise_acc_d = 1'b0;
          perr_acc_d  = 1'b0;
          // Nine data bits leave no room for parity in the 9-bit word, so drop to eight.
          if (data_bits >= 3'd4) begin
            nbits_d = par_en_in_s ? 4'd8 : 4'd9;
          end else begin
            nbits_d = {1'b0, data_bits} + 4'd5;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        timer_d = timer_next_s;
        if (at_sp2_s && bit_val_s) begin
          state_d = S_IDLE;
          timer_d = 24'd0;
        end else if (at_sp2_s) begin
          noise_acc_d = bit_noisy_s;
        end else if (end_of_bit_s) begin
          state_d = S_DATA;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        timer_d = timer_next_s;
        if (at_sp2_s) begin
          shreg_d[bit_cnt_q] = bit_val_s;
          noise_acc_d        = noise_acc_q | bit_noisy_s;
        end else if (end_of_bit_s) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == (nbits_q - 4'd1)) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_PARITY: begin
        timer_d = timer_next_s;
        if (at_sp2_s) begin
          perr_acc_d  = ((parity9(shreg_q) ^ bit_val_s) != par_odd_q);
          noise_acc_d = noise_acc_q | bit_noisy_s;
        end else if (end_of_bit_s) begin
          state_d = S_STOP;
        end else begin
          state_d = S_PARITY;
        end
      end
      S_STOP: begin
        timer_d = timer_next_s;
        if (at_sp1_s) begin
          valid_d = 1'b1;
          data_d  = shreg_q;
          noise_d = noise_acc_q | stop_noisy_s;
          perr_d  = perr_acc_q;
          ferr_d  = ~rx_s;
          timer_d = 24'd0;
          state_d = rx_s ? S_IDLE : S_WAIT_HIGH;
        end else begin
          state_d = S_STOP;
        end
      end
      S_WAIT_HIGH: begin
        if (rx_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_HIGH;
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = 24'd0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset presets the synchroniser to the idle line level.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync_q      <= {SYNC_STAGES{1'b1}};
      rx_prev_q   <= 1'b1;
      state_q     <= S_IDLE;
      timer_q     <= 24'd0;
      c_q         <= 24'd0;
      nbits_q     <= 4'd0;
      par_en_q    <= 1'b0;
      par_odd_q   <= 1'b0;
      bit_cnt_q   <= 4'd0;
      shreg_q     <= 9'd0;
      samp_q      <= 2'b11;
      noise_acc_q <= 1'b0;
      perr_acc_q  <= 1'b0;
      data_q      <= 9'd0;
      valid_q     <= 1'b0;
      noise_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      rx_prev_q   <= rx_prev_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      c_q         <= c_d;
      nbits_q     <= nbits_d;
      par_en_q    <= par_en_d;
      par_odd_q   <= par_odd_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      samp_q      <= samp_d;
      noise_acc_q <= noise_acc_d;
      perr_acc_q  <= perr_acc_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      noise_q     <= noise_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      busy_q      <= busy_d;
    end
  end

  assign data         = data_q;
  assign valid        = valid_q;
  assign noise_error  = noise_q;
  assign parity_error = perr_q;
  assign frame_error  = ferr_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_airi5c_uart_rx.sv
// Self-checking bench for airi5c_uart_rx: a frame generator drives the pin, a monitor collects
// valid pulses, and each test compares them with records predicted from the frame format rules.
module tb_airi5c_uart_rx;

  localparam int SYNC = 2;
`ifdef UART_RX_NOISE_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        n_reset;
  logic        rx;
  logic [2:0]  data_bits;
  logic [1:0]  parity;
  logic [1:0]  stop_bits;
  logic [23:0] c_bits;
  logic [8:0]  data;
  logic        valid, noise_error, parity_error, frame_error, busy;

  int     total = 0;
  int     bad = 0;
  longint cyc = 0;

  typedef struct {
    logic [8:0] data;
    logic       ne;
    logic       pe;
    logic       fe;
    longint     cyc;
  } rec_t;

  rec_t act_q[$];
  rec_t exp_q[$];
  rec_t a, e;

  airi5c_uart_rx #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .n_reset(n_reset), .rx(rx), .data_bits(data_bits), .parity(parity),
    .stop_bits(stop_bits), .c_bits(c_bits), .data(data), .valid(valid),
    .noise_error(noise_error), .parity_error(parity_error), .frame_error(frame_error),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      rec_t r;
      r.data = data;
      r.ne   = noise_error;
      r.pe   = parity_error;
      r.fe   = frame_error;
      r.cyc  = cyc;
      act_q.push_back(r);
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1 rx = 1'b1;
    end
  endtask

  // Drives one frame and queues the record the receiver should report for it.
  // Latency is counted from the first clock edge that samples the start bit.
  task automatic send_frame(input logic [8:0] word, input int db, input int par, input int sb,
                            input int c, input bit inv_par, input bit stop_low,
                            input int g_bit, input int g_lo, input int g_hi, input bit scramble);
    int sv[$];
    int sl[$];
    int n, p, pbit, stop_len;
    longint e0;
    logic [8:0] mask;
    logic v;
    rec_t ex;
    n    = (db >= 4) ? (((par == 1) || (par == 2)) ? 8 : 9) : db + 5;
    p    = ((par == 1) || (par == 2)) ? 1 : 0;
    mask = 9'((1 << n) - 1);
    data_bits = 3'(db);
    parity    = 2'(par);
    stop_bits = 2'(sb);
    c_bits    = 24'(c);
    sv.push_back(0);
    sl.push_back(c);
    for (int i = 0; i < n; i++) begin
      sv.push_back(int'((word >> i) & 9'd1));
      sl.push_back(c);
    end
    if (p == 1) begin
      pbit = $countones(word & mask) % 2;
      if (par == 1) pbit = pbit ^ 1;
      if (inv_par) pbit = pbit ^ 1;
      sv.push_back(pbit);
      sl.push_back(c);
    end
    stop_len = (sb == 1) ? c + c / 2 : ((sb == 2) ? 2 * c : c);
    sv.push_back(stop_low ? 0 : 1);
    sl.push_back(stop_len);
    e0 = 0;
    for (int s = 0; s < sv.size(); s++) begin
      for (int t = 0; t < sl[s]; t++) begin
        @(posedge clk);
        #1;
        if (s == 0 && t == 0) e0 = cyc;
        if (scramble && s == 2 && t == 0) begin
          data_bits = 3'($urandom_range(0, 7));
          parity    = 2'($urandom_range(0, 3));
          stop_bits = 2'($urandom_range(0, 3));
          c_bits    = 24'($urandom_range(0, 5000));
        end
        v = sv[s][0];
        if (s == g_bit && t >= g_lo && t <= g_hi) v = ~v;
        rx = v;
      end
    end
    ex.data = word & mask;
    ex.ne   = FILT && (g_bit >= 0);
    ex.pe   = inv_par && (p == 1);
    ex.fe   = stop_low;
    ex.cyc  = e0 + SYNC + 2 + longint'((1 + n + p) * c + (c >> 1));
    exp_q.push_back(ex);
  endtask

  task automatic test_reset;
    n_reset = 1'b0;
    rx = 1'b1;
    data_bits = 3'd3; parity = 2'd0; stop_bits = 2'd0; c_bits = 24'd64;
    repeat (3) @(negedge clk);
    total++;
    if (data !== 9'd0) begin
      bad++; $display("FAIL reset_data: got %h want 000", data);
    end
    total++;
    if (valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid: got %b want 0", valid);
    end
    total++;
    if ({noise_error, parity_error, frame_error, busy} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags: got %b want 0000", {noise_error, parity_error, frame_error, busy});
    end
    @(posedge clk);
    #1 n_reset = 1'b1;
    idle(20);
  endtask

  task automatic test_hello;
    string s;
    s = "Hello World!";
    for (int i = 0; i < s.len(); i++) send_frame(9'(s[i]), 3, 0, 0, 200, 0, 0, -1, 0, 0, 0);
    idle(400);
    total++;
    if (act_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL hello_count: got %0d want %0d", act_q.size(), exp_q.size());
    end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front(); total++;
      if ({a.data, a.ne, a.pe, a.fe} !== {e.data, e.ne, e.pe, e.fe} || a.cyc != e.cyc) begin
        bad++; $display("FAIL hello_frame: got %h nf%b pe%b fe%b t%0d want %h nf%b pe%b fe%b t%0d",
                        a.data, a.ne, a.pe, a.fe, a.cyc, e.data, e.ne, e.pe, e.fe, e.cyc);
      end
    end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_noise;
    // Data bit 5 is frame segment 6; the glitch covers only the late sample point.
    send_frame(9'h081, 3, 0, 0, 278, 0, 0, 6, 156 - 8, 156 + 8, 0);
    idle(400);
    total++;
    if (act_q.size() !== 1) begin
      bad++; $display("FAIL noise_count: got %0d want 1", act_q.size());
    end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front(); total++;
      if ({a.data, a.ne, a.pe, a.fe} !== {e.data, e.ne, e.pe, e.fe} || a.cyc != e.cyc) begin
        bad++; $display("FAIL noise_frame: got %h nf%b pe%b fe%b t%0d want %h nf%b pe%b fe%b t%0d",
                        a.data, a.ne, a.pe, a.fe, a.cyc, e.data, e.ne, e.pe, e.fe, e.cyc);
      end
    end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_parity;
    send_frame(9'h061, 2, 2, 1, 1667, 1, 0, -1, 0, 0, 0);
    idle(1000);
    total++;
    if (act_q.size() !== 1) begin
      bad++; $display("FAIL parity_count: got %0d want 1", act_q.size());
    end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front(); total++;
      if ({a.data, a.ne, a.pe, a.fe} !== {e.data, e.ne, e.pe, e.fe} || a.cyc != e.cyc) begin
        bad++; $display("FAIL parity_frame: got %h nf%b pe%b fe%b t%0d want %h nf%b pe%b fe%b t%0d",
                        a.data, a.ne, a.pe, a.fe, a.cyc, e.data, e.ne, e.pe, e.fe, e.cyc);
      end
    end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_frame_error;
    send_frame(9'h02A, 1, 1, 2, 556, 0, 1, -1, 0, 0, 0);
    idle(3 * 556);
    total++;
    if (act_q.size() !== 1) begin
      bad++; $display("FAIL ferr_count: got %0d want 1", act_q.size());
    end
    send_frame(9'h015, 1, 1, 2, 556, 0, 0, -1, 0, 0, 0);
    idle(600);
    total++;
    if (act_q.size() !== 2) begin
      bad++; $display("FAIL ferr_total: got %0d want 2", act_q.size());
    end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front(); total++;
      if ({a.data, a.ne, a.pe, a.fe} !== {e.data, e.ne, e.pe, e.fe} || a.cyc != e.cyc) begin
        bad++; $display("FAIL ferr_frame: got %h nf%b pe%b fe%b t%0d want %h nf%b pe%b fe%b t%0d",
                        a.data, a.ne, a.pe, a.fe, a.cyc, e.data, e.ne, e.pe, e.fe, e.cyc);
      end
    end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_glitch;
    longint e0, target;
    send_frame(9'h1A5, 4, 0, 0, 100, 0, 0, -1, 0, 0, 0);
    idle(300);
    total++;
    if (act_q.size() !== 1) begin
      bad++; $display("FAIL nine_count: got %0d want 1", act_q.size());
    end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front(); total++;
      if ({a.data, a.ne, a.pe, a.fe} !== {e.data, e.ne, e.pe, e.fe} || a.cyc != e.cyc) begin
        bad++; $display("FAIL nine_frame: got %h nf%b pe%b fe%b t%0d want %h nf%b pe%b fe%b t%0d",
                        a.data, a.ne, a.pe, a.fe, a.cyc, e.data, e.ne, e.pe, e.fe, e.cyc);
      end
    end
    act_q.delete(); exp_q.delete();
    // 20-cycle low pulse: rejected at the late sample point (50 + 6) of the start bit.
    e0 = 0;
    for (int t = 0; t < 21; t++) begin
      @(posedge clk);
      #1;
      if (t == 0) e0 = cyc;
      rx = (t < 20) ? 1'b0 : 1'b1;
    end
    target = e0 + SYNC + 1 + 56;
    for (int k = 0; k < 500 && cyc < target; k++) @(negedge clk);
    total++;
    if (cyc != target || busy !== 1'b1) begin
      bad++; $display("FAIL glitch_busy_hi: got busy=%b at t%0d want 1 at t%0d", busy, cyc, target);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL glitch_busy_lo: got %b want 0", busy);
    end
    // Bit period below 16 cycles: the receiver must ignore the line entirely.
    c_bits = 24'd15;
    for (int t = 0; t < 100; t++) begin
      @(posedge clk);
      #1 rx = 1'b0;
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL short_c_busy: got %b want 0", busy);
    end
    idle(300);
    total++;
    if (act_q.size() !== 0) begin
      bad++; $display("FAIL glitch_novalid: got %0d pulses want 0", act_q.size());
    end
    act_q.delete();
  endtask

  task automatic test_reset_abort;
    data_bits = 3'd3; parity = 2'd0; stop_bits = 2'd0; c_bits = 24'd64;
    for (int t = 0; t < 64 * 4 + 20; t++) begin
      @(posedge clk);
      #1;
      if (t < 64) rx = 1'b0;
      else rx = 1'((9'h055 >> ((t / 64) - 1)) & 9'd1);
    end
    n_reset = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, valid, data} !== 11'd0) begin
      bad++; $display("FAIL abort_reset_state: got busy=%b valid=%b data=%h want 0 0 000", busy, valid, data);
    end
    rx = 1'b1;
    @(posedge clk);
    #1 n_reset = 1'b1;
    idle(300);
    total++;
    if (act_q.size() !== 0) begin
      bad++; $display("FAIL abort_novalid: got %0d pulses want 0", act_q.size());
    end
    send_frame(9'h03C, 3, 0, 0, 64, 0, 0, -1, 0, 0, 0);
    idle(200);
    total++;
    if (act_q.size() !== 1) begin
      bad++; $display("FAIL abort_count: got %0d want 1", act_q.size());
    end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front(); total++;
      if ({a.data, a.ne, a.pe, a.fe} !== {e.data, e.ne, e.pe, e.fe} || a.cyc != e.cyc) begin
        bad++; $display("FAIL abort_frame: got %h nf%b pe%b fe%b t%0d want %h nf%b pe%b fe%b t%0d",
                        a.data, a.ne, a.pe, a.fe, a.cyc, e.data, e.ne, e.pe, e.fe, e.cyc);
      end
    end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_random;
    int c, db, par, sb, gap;
    bit inv;
    for (int i = 0; i < 25; i++) begin
      c   = $urandom_range(16, 60);
      db  = $urandom_range(0, 4);
      par = $urandom_range(0, 3);
      sb  = $urandom_range(0, 3);
      inv = ((par == 1) || (par == 2)) && ($urandom_range(0, 1) == 1);
      send_frame(9'($urandom_range(0, 511)), db, par, sb, c, inv, 0, -1, 0, 0, 1);
      gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 2 * c);
      idle(gap);
    end
    idle(200);
    total++;
    if (act_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL random_count: got %0d want %0d", act_q.size(), exp_q.size());
    end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front(); total++;
      if ({a.data, a.ne, a.pe, a.fe} !== {e.data, e.ne, e.pe, e.fe} || a.cyc != e.cyc) begin
        bad++; $display("FAIL random_frame: got %h nf%b pe%b fe%b t%0d want %h nf%b pe%b fe%b t%0d",
                        a.data, a.ne, a.pe, a.fe, a.cyc, e.data, e.ne, e.pe, e.fe, e.cyc);
      end
    end
    act_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset;
    test_hello;
    test_noise;
    test_parity;
    test_frame_error;
    test_glitch;
    test_reset_abort;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
